// File: rtl/mult_share_arbiter_if.sv
// Request/operand/result bundle between four requesters, the
// arbiter and the shared 4x4 multiplier.
interface mult_share_arbiter_if;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  ack;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_c;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        res_ready;

  modport master (
    output req, a_bus, b_bus, mul_c, res_ready,
    input  ack, mul_a, mul_b, res_valid, res_id, res_data
  );

  modport slave (
    input  req, a_bus, b_bus, mul_c, res_ready,
    output ack, mul_a, mul_b, res_valid, res_id, res_data
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Arbitrates four requesters onto one shared 4x4 multiplier:
// grant in IDLE, capture product in CALC, hold result in OUT.
module mult_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] idx;
  logic       hit;
  logic       grant;

  // Round-robin scans from last+1; fixed priority scans from 0.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = RR_EN ? last + 2'(k + 1) : 2'(k);
      if (!hit && bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  // Ack is issued in the same cycle the operands are latched.
  assign grant   = (state == IDLE) && rst_n && hit;
  assign bus.ack = grant ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 2'd3;
      bus.mul_a     <= 4'd0;
      bus.mul_b     <= 4'd0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 2'd0;
      bus.res_data  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            bus.mul_a  <= bus.a_bus[{win, 2'b00} +: 4];
            bus.mul_b  <= bus.b_bus[{win, 2'b00} +: 4];
            bus.res_id <= win;
            last       <= win;
            state      <= CALC;
          end
        end
        CALC: begin
          bus.res_data  <= bus.mul_c;
          bus.res_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench: round-robin and fixed-priority instances, each
// with a behavioural 4x4 multiplier on its mul_c return path.
module tb_mult_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mult_share_arbiter_if b0 ();
  mult_share_arbiter_if b1 ();

  mult_share_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  mult_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  assign b0.mul_c = {4'd0, b0.mul_a} * {4'd0, b0.mul_b};
  assign b1.mul_c = {4'd0, b1.mul_a} * {4'd0, b1.mul_b};

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_prod [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    b0.req = 4'd0; b0.a_bus = 16'd0; b0.b_bus = 16'd0;
    b0.res_ready = 1'b0;
    b1.req = 4'd0; b1.a_bus = 16'd0; b1.b_bus = 16'd0;
    b1.res_ready = 1'b0;
    rr_prod = '{8'd10, 8'd18, 8'd28, 8'd40};

    // reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ack", 16'(b0.ack), 16'd0);
    chk("rst_mul_a", 16'(b0.mul_a), 16'd0);
    chk("rst_mul_b", 16'(b0.mul_b), 16'd0);
    chk("rst_valid", 16'(b0.res_valid), 16'd0);
    chk("rst_id", 16'(b0.res_id), 16'd0);
    chk("rst_data", 16'(b0.res_data), 16'd0);
    tick();
    rst_n = 1'b1;

    // round robin with all four requesting
    b0.res_ready = 1'b1;
    b0.a_bus = 16'h5432;
    b0.b_bus = 16'h8765;
    b0.req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("rr_ack", 16'(b0.ack), 16'(4'b0001 << (g % 4)));
      tick();
      @(negedge clk);
      chk("rr_calc_ack", 16'(b0.ack), 16'd0);
      tick();
      @(negedge clk);
      chk("rr_valid", 16'(b0.res_valid), 16'd1);
      chk("rr_id", 16'(b0.res_id), 16'(g % 4));
      chk("rr_data", 16'(b0.res_data), 16'(rr_prod[g % 4]));
      chk("rr_out_ack", 16'(b0.ack), 16'd0);
      tick();
    end
    b0.req = 4'd0;

    // single request, 7*9
    tick();
    b0.req = 4'b0001; b0.a_bus = 16'h0007; b0.b_bus = 16'h0009;
    @(negedge clk);
    chk("s_ack", 16'(b0.ack), 16'b0001);
    tick();
    b0.req = 4'd0; b0.a_bus = 16'd0; b0.b_bus = 16'd0;
    @(negedge clk);
    chk("s_ack_off", 16'(b0.ack), 16'd0);
    chk("s_mul_a", 16'(b0.mul_a), 16'd7);
    chk("s_mul_b", 16'(b0.mul_b), 16'd9);
    chk("s_early", 16'(b0.res_valid), 16'd0);
    tick();
    @(negedge clk);
    chk("s_valid", 16'(b0.res_valid), 16'd1);
    chk("s_id", 16'(b0.res_id), 16'd0);
    chk("s_data", 16'(b0.res_data), 16'd63);
    tick();
    @(negedge clk);
    chk("s_done", 16'(b0.res_valid), 16'd0);

    // operands change after ack: 3*4 latched, 5*5 ignored
    tick();
    b0.req = 4'b0100; b0.a_bus = 16'h0300; b0.b_bus = 16'h0400;
    @(negedge clk);
    chk("op_ack", 16'(b0.ack), 16'b0100);
    tick();
    b0.req = 4'd0; b0.a_bus = 16'h0500; b0.b_bus = 16'h0500;
    tick();
    @(negedge clk);
    chk("op_id", 16'(b0.res_id), 16'd2);
    chk("op_data", 16'(b0.res_data), 16'd12);
    tick();

    // back-pressure with 15*15, competing request waits
    b0.res_ready = 1'b0;
    b0.req = 4'b0010; b0.a_bus = 16'h00f0; b0.b_bus = 16'h00f0;
    @(negedge clk);
    chk("bp_ack", 16'(b0.ack), 16'b0010);
    tick();
    b0.req = 4'd0;
    tick();
    b0.req = 4'b1000; b0.a_bus = 16'h2000; b0.b_bus = 16'h3000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 16'(b0.res_valid), 16'd1);
      chk("bp_data", 16'(b0.res_data), 16'd225);
      chk("bp_id", 16'(b0.res_id), 16'd1);
      chk("bp_ack_hold", 16'(b0.ack), 16'd0);
      tick();
    end
    b0.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_hs", 16'(b0.ack), 16'd0);
    tick();
    @(negedge clk);
    chk("bp_clear", 16'(b0.res_valid), 16'd0);
    chk("bp_next_ack", 16'(b0.ack), 16'b1000);
    tick();
    b0.req = 4'd0;
    tick();
    @(negedge clk);
    chk("bp_next_id", 16'(b0.res_id), 16'd3);
    chk("bp_next_data", 16'(b0.res_data), 16'd6);
    tick();

    // reset while a result is held in OUT
    b0.res_ready = 1'b0;
    b0.req = 4'b0001; b0.a_bus = 16'h0006; b0.b_bus = 16'h0007;
    tick();
    b0.req = 4'd0;
    tick();
    @(negedge clk);
    chk("ro_valid", 16'(b0.res_valid), 16'd1);
    chk("ro_data", 16'(b0.res_data), 16'd42);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ro_rst_valid", 16'(b0.res_valid), 16'd0);
    chk("ro_rst_data", 16'(b0.res_data), 16'd0);
    chk("ro_rst_id", 16'(b0.res_id), 16'd0);
    chk("ro_rst_mul_a", 16'(b0.mul_a), 16'd0);
    chk("ro_rst_mul_b", 16'(b0.mul_b), 16'd0);
    chk("ro_rst_ack", 16'(b0.ack), 16'd0);
    tick();
    b0.req = 4'b0010; b0.a_bus = 16'h0020; b0.b_bus = 16'h0030;
    @(negedge clk);
    chk("ro_ack", 16'(b0.ack), 16'b0010);
    tick();
    b0.req = 4'd0;
    b0.res_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ro_id", 16'(b0.res_id), 16'd1);
    chk("ro_data2", 16'(b0.res_data), 16'd6);
    tick();

    // fixed priority starves requester 2
    b1.res_ready = 1'b1;
    b1.req = 4'b0110; b1.a_bus = 16'h0020; b1.b_bus = 16'h0050;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("fp_ack", 16'(b1.ack), 16'b0010);
      tick();
      tick();
      @(negedge clk);
      chk("fp_id", 16'(b1.res_id), 16'd1);
      chk("fp_data", 16'(b1.res_data), 16'd10);
      tick();
    end
    b1.req = 4'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
